// File: rtl/wb_stage_pipelined_if.sv
// Bundle between the MEM stage and the writeback stage: M-side captures, stall/flush
// control, and the registered W-side results sent to the register file and forwarding network.
interface wb_stage_pipelined_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
);
  logic                      StallW;
  logic                      FlushW;
  logic                      RegWriteM;
  logic                      MemtoRegM;
  logic                      LinkM;
  logic [2:0]                LoadTypeM;
  logic [DATA_WIDTH-1:0]     ALUOutM;
  logic [DATA_WIDTH-1:0]     ReadDataM;
  logic [DATA_WIDTH-1:0]     PCPlus8M;
  logic [REG_ADDR_WIDTH-1:0] WriteRegM;

  logic                      RegWriteW;
  logic [REG_ADDR_WIDTH-1:0] WriteRegW;
  logic [DATA_WIDTH-1:0]     ResultW;
  logic                      ValidW;
  logic                      MisalignW;

  modport master (
    output StallW, FlushW, RegWriteM, MemtoRegM, LinkM, LoadTypeM,
           ALUOutM, ReadDataM, PCPlus8M, WriteRegM,
    input  RegWriteW, WriteRegW, ResultW, ValidW, MisalignW
  );

  modport slave (
    input  StallW, FlushW, RegWriteM, MemtoRegM, LinkM, LoadTypeM,
           ALUOutM, ReadDataM, PCPlus8M, WriteRegM,
    output RegWriteW, WriteRegW, ResultW, ValidW, MisalignW
  );
endinterface

// File: rtl/wb_stage_pipelined.sv
// Writeback stage: MEM/WB register with stall/flush, sub-word load extraction,
// result select (link > load > ALU) and qualified register-file write enable.
module wb_stage_pipelined #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int ENABLE_LINK    = 1
) (
  input logic                CLK,
  input logic                RST,
  wb_stage_pipelined_if.slave bus
);
  localparam int   OFS_W   = $clog2(DATA_WIDTH / 8);
  localparam logic LINK_ON = (ENABLE_LINK != 0);

  localparam logic [2:0] LT_LH  = 3'b001;
  localparam logic [2:0] LT_LHU = 3'b010;
  localparam logic [2:0] LT_LB  = 3'b011;
  localparam logic [2:0] LT_LBU = 3'b100;

  logic                      valid_q;
  logic                      regwrite_q;
  logic                      memtoreg_q;
  logic                      link_q;
  logic [2:0]                loadtype_q;
  logic [DATA_WIDTH-1:0]     aluout_q;
  logic [DATA_WIDTH-1:0]     readdata_q;
  logic [DATA_WIDTH-1:0]     pcplus8_q;
  logic [REG_ADDR_WIDTH-1:0] writereg_q;

  // Flush beats stall; a cleared register makes every W output read as zero.
  always_ff @(posedge CLK) begin
    if (RST || bus.FlushW) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      link_q     <= 1'b0;
      loadtype_q <= '0;
      aluout_q   <= '0;
      readdata_q <= '0;
      pcplus8_q  <= '0;
      writereg_q <= '0;
    end else if (!bus.StallW) begin
      valid_q    <= 1'b1;
      regwrite_q <= bus.RegWriteM;
      memtoreg_q <= bus.MemtoRegM;
      link_q     <= bus.LinkM & LINK_ON;
      loadtype_q <= bus.LoadTypeM;
      aluout_q   <= bus.ALUOutM;
      readdata_q <= bus.ReadDataM;
      pcplus8_q  <= bus.PCPlus8M;
      writereg_q <= bus.WriteRegM;
    end
  end

  logic [OFS_W-1:0]      ofs;
  logic [OFS_W-1:0]      hofs;
  logic [DATA_WIDTH-1:0] byte_shift;
  logic [DATA_WIDTH-1:0] half_shift;
  logic [7:0]            lbyte;
  logic [15:0]           lhalf;
  logic                  is_half;
  logic                  is_byte;
  logic [DATA_WIDTH-1:0] load_data;
  logic [DATA_WIDTH-1:0] result;
  logic                  misalign;

  // Halfword lane ignores the low offset bit so a misaligned LH still shows a defined value.
  always_comb begin
    ofs        = aluout_q[OFS_W-1:0];
    hofs       = {ofs[OFS_W-1:1], 1'b0};
    byte_shift = readdata_q >> {ofs, 3'b000};
    half_shift = readdata_q >> {hofs, 3'b000};
    lbyte      = byte_shift[7:0];
    lhalf      = half_shift[15:0];
    is_half    = (loadtype_q == LT_LH) || (loadtype_q == LT_LHU);
    is_byte    = (loadtype_q == LT_LB) || (loadtype_q == LT_LBU);

    case (loadtype_q)
      LT_LH:   load_data = {{(DATA_WIDTH-16){lhalf[15]}}, lhalf};
      LT_LHU:  load_data = {{(DATA_WIDTH-16){1'b0}}, lhalf};
      LT_LB:   load_data = {{(DATA_WIDTH-8){lbyte[7]}}, lbyte};
      LT_LBU:  load_data = {{(DATA_WIDTH-8){1'b0}}, lbyte};
      default: load_data = readdata_q;
    endcase

    misalign = 1'b0;
    if (valid_q && memtoreg_q) begin
      if (is_half)       misalign = ofs[0];
      else if (!is_byte) misalign = (ofs != '0);
    end

    if (link_q)          result = pcplus8_q;
    else if (memtoreg_q) result = load_data;
    else                 result = aluout_q;
  end

  assign bus.ResultW   = result;
  assign bus.MisalignW = misalign;
  assign bus.ValidW    = valid_q;
  assign bus.WriteRegW = writereg_q;
  assign bus.RegWriteW = regwrite_q & valid_q & ~misalign & (writereg_q != '0);
endmodule

// File: tb/tb_wb_stage_pipelined.sv
// Self-checking bench for wb_stage_pipelined: expectations are queued as stimulus is
// driven and popped one cycle later when the W register presents the result.
module tb_wb_stage_pipelined;
  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  wb_stage_pipelined_if #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) bus ();
  wb_stage_pipelined_if #(.DATA_WIDTH(64), .REG_ADDR_WIDTH(5)) bus64 ();

  wb_stage_pipelined #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .ENABLE_LINK(1)) dut (
    .CLK(CLK), .RST(RST), .bus(bus)
  );
  wb_stage_pipelined #(.DATA_WIDTH(64), .REG_ADDR_WIDTH(5), .ENABLE_LINK(1)) dut64 (
    .CLK(CLK), .RST(RST), .bus(bus64)
  );

  typedef struct { logic [39:0] e; string n; } exp_t;
  typedef struct { logic [71:0] e; string n; } exp64_t;
  exp_t   sb[$];
  exp64_t sb64[$];
  int compared   = 0;
  int mismatched = 0;

  function automatic logic [39:0] pk(logic v, logic rw, logic mis, logic [4:0] wr, logic [31:0] r);
    return {v, rw, mis, wr, r};
  endfunction

  function automatic logic [71:0] pk64(logic v, logic rw, logic mis, logic [4:0] wr, logic [63:0] r);
    return {v, rw, mis, wr, r};
  endfunction

  function automatic logic [39:0] obs();
    return {bus.ValidW, bus.RegWriteW, bus.MisalignW, bus.WriteRegW, bus.ResultW};
  endfunction

  function automatic logic [71:0] obs64();
    return {bus64.ValidW, bus64.RegWriteW, bus64.MisalignW, bus64.WriteRegW, bus64.ResultW};
  endfunction

  task automatic applyStimulus(input logic rw, input logic m2r, input logic lnk,
                               input logic [2:0] lt, input logic [31:0] alu,
                               input logic [31:0] rd, input logic [31:0] pc8,
                               input logic [4:0] wr, input logic stall, input logic flush);
    bus.RegWriteM = rw;  bus.MemtoRegM = m2r; bus.LinkM    = lnk;
    bus.LoadTypeM = lt;  bus.ALUOutM   = alu; bus.ReadDataM = rd;
    bus.PCPlus8M  = pc8; bus.WriteRegM = wr;  bus.StallW   = stall;
    bus.FlushW    = flush;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    RST = 1'b1;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 3'd3, 32'hDEAD_BEEF, 32'h1234_5678, 32'h40, 5'd9, 1'b0, 1'b0);
      sb.push_back('{pk(1'b0, 1'b0, 1'b0, 5'd0, 32'h0), "reset_hold"});
      step();
      e = sb.pop_front();
      compared++;
      if (obs() !== e.e) begin
        mismatched++;
        $display("[TB] FAIL %s: got %h expected %h", e.n, obs(), e.e);
      end
    end
    RST = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    sb.push_back('{pk(1'b1, 1'b0, 1'b0, 5'd0, 32'h0), "idle_after_reset"});
    step();
    e = sb.pop_front();
    compared++;
    if (obs() !== e.e) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", e.n, obs(), e.e);
    end
  endtask

  task automatic test_alu_link_zero();
    exp_t e;
    logic [31:0] alu[4] = '{32'h0000_1234, 32'h0000_0000, 32'h0000_0055, 32'h0000_0000};
    logic [31:0] rdv[4] = '{32'h0, 32'hCAFE_0000, 32'h0, 32'h8765_4321};
    logic [4:0]  wr[4]  = '{5'd8, 5'd31, 5'd0, 5'd3};
    logic        m2r[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic        lnk[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [2:0]  lt[4]  = '{3'd0, 3'd0, 3'd0, 3'd5};
    logic [39:0] ex[4];
    ex[0] = pk(1'b1, 1'b1, 1'b0, 5'd8,  32'h0000_1234);
    ex[1] = pk(1'b1, 1'b1, 1'b0, 5'd31, 32'h0040_0010);
    ex[2] = pk(1'b1, 1'b0, 1'b0, 5'd0,  32'h0000_0055);
    ex[3] = pk(1'b1, 1'b1, 1'b0, 5'd3,  32'h8765_4321);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, m2r[i], lnk[i], lt[i], alu[i], rdv[i], 32'h0040_0010, wr[i], 1'b0, 1'b0);
      sb.push_back('{ex[i], $sformatf("alu_link_zero_%0d", i)});
      step();
      e = sb.pop_front();
      compared++;
      if (obs() !== e.e) begin
        mismatched++;
        $display("[TB] FAIL %s: got %h expected %h", e.n, obs(), e.e);
      end
    end
  endtask

  task automatic test_subword();
    exp_t e;
    logic [31:0] alu[7] = '{32'h1000_0002, 32'h1000_0003, 32'h1000_0002, 32'h1000_0000,
                            32'h1000_0001, 32'h1000_0003, 32'h1000_0003};
    logic [2:0]  lt[7]  = '{3'd3, 3'd4, 3'd1, 3'd2, 3'd0, 3'd1, 3'd3};
    logic [39:0] ex[7];
    ex[0] = pk(1'b1, 1'b1, 1'b0, 5'd10, 32'hFFFF_FFFF);
    ex[1] = pk(1'b1, 1'b1, 1'b0, 5'd11, 32'h0000_0080);
    ex[2] = pk(1'b1, 1'b1, 1'b0, 5'd12, 32'hFFFF_80FF);
    ex[3] = pk(1'b1, 1'b1, 1'b0, 5'd13, 32'h0000_7F01);
    ex[4] = pk(1'b1, 1'b0, 1'b1, 5'd14, 32'h80FF_7F01);
    ex[5] = pk(1'b1, 1'b0, 1'b1, 5'd15, 32'hFFFF_80FF);
    ex[6] = pk(1'b1, 1'b1, 1'b0, 5'd16, 32'hFFFF_FF80);
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, lt[i], alu[i], 32'h80FF_7F01, 32'h0, 5'(10 + i), 1'b0, 1'b0);
      sb.push_back('{ex[i], $sformatf("subword_%0d", i)});
      step();
      e = sb.pop_front();
      compared++;
      if (obs() !== e.e) begin
        mismatched++;
        $display("[TB] FAIL %s: got %h expected %h", e.n, obs(), e.e);
      end
    end
  endtask

  task automatic test_back_to_back_stall_flush();
    exp_t e;
    logic [39:0] a;
    a = pk(1'b1, 1'b1, 1'b0, 5'd5, 32'h0000_A5A5);
    applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 32'h0000_A5A5, 32'h0, 32'h0, 5'd5, 1'b0, 1'b0);
    sb.push_back('{a, "stall_load_a"});
    for (int i = 0; i < 3; i++)
      sb.push_back('{a, $sformatf("stall_hold_%0d", i)});
    sb.push_back('{pk(1'b0, 1'b0, 1'b0, 5'd0, 32'h0), "flush_with_stall"});
    sb.push_back('{pk(1'b1, 1'b1, 1'b0, 5'd4, 32'h0000_0077), "load_b"});
    sb.push_back('{pk(1'b0, 1'b0, 1'b0, 5'd0, 32'h0), "reset_mid_stall"});
    for (int i = 0; i < 7; i++) begin
      if (i >= 1 && i <= 3)
        applyStimulus(1'b1, 1'b1, 1'b1, 3'd3, $urandom, $urandom, $urandom, 5'(20 + i), 1'b1, 1'b0);
      else if (i == 4)
        applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 32'h1, 32'h0, 32'h0, 5'd6, 1'b1, 1'b1);
      else if (i == 5)
        applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 32'h77, 32'h0, 32'h0, 5'd4, 1'b0, 1'b0);
      else if (i == 6) begin
        RST = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 32'h99, 32'h0, 32'h0, 5'd7, 1'b1, 1'b0);
      end
      step();
      e = sb.pop_front();
      compared++;
      if (obs() !== e.e) begin
        mismatched++;
        $display("[TB] FAIL %s: got %h expected %h", e.n, obs(), e.e);
      end
    end
    RST = 1'b0;
  endtask

  task automatic test_wide();
    exp64_t e;
    logic [63:0] alu[5] = '{64'h7, 64'h7, 64'h6, 64'h4, 64'h8};
    logic [2:0]  lt[5]  = '{3'd3, 3'd4, 3'd1, 3'd0, 3'd0};
    logic [71:0] ex[5];
    ex[0] = pk64(1'b1, 1'b1, 1'b0, 5'd1, 64'hFFFF_FFFF_FFFF_FF80);
    ex[1] = pk64(1'b1, 1'b1, 1'b0, 5'd2, 64'h0000_0000_0000_0080);
    ex[2] = pk64(1'b1, 1'b1, 1'b0, 5'd3, 64'hFFFF_FFFF_FFFF_8011);
    ex[3] = pk64(1'b1, 1'b0, 1'b1, 5'd4, 64'h8011_2233_4455_6677);
    ex[4] = pk64(1'b1, 1'b1, 1'b0, 5'd5, 64'h8011_2233_4455_6677);
    for (int i = 0; i < 5; i++) begin
      bus64.RegWriteM = 1'b1;  bus64.MemtoRegM = 1'b1; bus64.LinkM  = 1'b0;
      bus64.LoadTypeM = lt[i]; bus64.ALUOutM   = alu[i];
      bus64.ReadDataM = 64'h8011_2233_4455_6677;
      bus64.PCPlus8M  = 64'h0; bus64.WriteRegM = 5'(1 + i);
      bus64.StallW    = 1'b0;  bus64.FlushW    = 1'b0;
      sb64.push_back('{ex[i], $sformatf("wide_%0d", i)});
      step();
      e = sb64.pop_front();
      compared++;
      if (obs64() !== e.e) begin
        mismatched++;
        $display("[TB] FAIL %s: got %h expected %h", e.n, obs64(), e.e);
      end
    end
  endtask

  initial begin
    RST = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    bus64.RegWriteM = 1'b0; bus64.MemtoRegM = 1'b0; bus64.LinkM = 1'b0;
    bus64.LoadTypeM = 3'd0; bus64.ALUOutM = '0; bus64.ReadDataM = '0;
    bus64.PCPlus8M  = '0;   bus64.WriteRegM = '0; bus64.StallW = 1'b0; bus64.FlushW = 1'b0;
    #1;
    test_reset();
    test_alu_link_zero();
    test_subword();
    test_back_to_back_stall_flush();
    test_wide();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/wb_stage_pipelined.md
Name: wb_stage_pipelined

Overview:
- Parametrised next-generation writeback stage for the pipelined MIPS core.
- Contains the MEM/WB pipeline register, with stall and flush control.
- Extracts sub-word loads (byte or halfword, signed or unsigned) and selects among ALU, load and link (PC+8) results.
- Suppresses writes to register 0 and to misaligned loads. Drives register-file write port and forwarding result.

Parameters:
- DATA_WIDTH, 32, datapath width; power of two, minimum 32.
- REG_ADDR_WIDTH, 5, register-file address width.
- ENABLE_LINK, 1, 1 enables the PC+8 link source; 0 ties the link path off (LinkM ignored).

Ports:
- CLK  input  1  core clock; all state updates on rising edge.
- RST  input  1  synchronous active-high reset.
- StallW  input  1  hold the WB register contents.
- FlushW  input  1  load a bubble into the WB register.
- RegWriteM  input  1  register-write enable from MEM.
- MemtoRegM  input  1  selects load data as the result.
- LinkM  input  1  selects PCPlus8M as the result (JAL/JALR).
- LoadTypeM  input  3  000 full word, 001 LH, 010 LHU, 011 LB, 100 LBU; codes 101–111 treated as 000.
- ALUOutM  input  DATA_WIDTH  ALU result / load effective address.
- ReadDataM  input  DATA_WIDTH  raw aligned data-memory word.
- PCPlus8M  input  DATA_WIDTH  link value.
- WriteRegM  input  REG_ADDR_WIDTH  destination register.
- RegWriteW  output  1  qualified write enable to the register file.
- WriteRegW  output  REG_ADDR_WIDTH  registered destination register.
- ResultW  output  DATA_WIDTH  write data; also the forwarding source.
- ValidW  output  1  WB slot holds a real instruction.
- MisalignW  output  1  WB slot is a misaligned load (exception flag).

Behaviour:
- WB register captures all M-side inputs on each rising CLK.
  - Priority: RST > FlushW > StallW > load.
- RST or FlushW: all stored fields cleared to zero; ValidW=0.
  - With the register cleared, all outputs are 0: RegWriteW=0, WriteRegW=0, ResultW=0, MisalignW=0.
- StallW=1, no flush: register holds; outputs stable.
- Normal load: ValidW<=1, all fields captured.
- ResultW, RegWriteW and MisalignW are combinational from registered fields only. No M-side input reaches W outputs within the same cycle, so latency M→W is exactly 1 cycle.
- Result select priority: link (when ENABLE_LINK=1 and LinkW=1) > MemtoRegW (extracted load data) > ALUOutW.
- Lane offset: OFS = ALUOutW[log2(DATA_WIDTH/8)-1:0]. Little-endian, lane 0 = bits [7:0].
- Extraction rules:
  - LB: byte at lane OFS, sign-extended to DATA_WIDTH.
  - LBU: same byte, zero-extended.
  - LH: halfword at byte offset OFS with OFS[0]=0, sign-extended.
  - LHU: same halfword, zero-extended.
  - Full word: ReadDataW unchanged.
- Misalignment applies only when MemtoRegW=1 and ValidW=1:
  - Full word with OFS≠0 → MisalignW=1.
  - LH/LHU with OFS[0]=1 → MisalignW=1.
  - Byte loads are never misaligned.
- RegWriteW = RegWriteStoredW & ValidW & ~MisalignW & (WriteRegW≠0).
- When the write is suppressed, ResultW still shows the computed value (debug visibility only).
- Simultaneous FlushW and StallW: flush wins.
- RST mid-stall clears the register. The first post-reset cycle has ValidW=0.
- No internal multi-cycle state beyond the WB register. Every output is defined in every cycle.

Test Plan:
- Reset then idle: RST=1 for 2 cycles, release → all outputs 0, ValidW=0. Same after a further cycle with RegWriteM=0 inputs and ValidW=1.
- ALU pass-through: RegWriteM=1, MemtoRegM=0, ALUOutM=0x0000_1234, WriteRegM=8 → next cycle RegWriteW=1, WriteRegW=8, ResultW=0x0000_1234.
- Sub-word loads with ReadDataM=0x80FF_7F01:
  - LB at ALUOut=…2 → 0xFFFF_FFFF.
  - LBU at ALUOut=…3 → 0x0000_0080.
  - LH at ALUOut=…2 → 0xFFFF_80FF.
  - LHU at ALUOut=…0 → 0x0000_7F01.
- Misalignment: LW at ALUOut=0x…1 → MisalignW=1, RegWriteW=0. LH at 0x…3 → MisalignW=1. LB at 0x…3 → MisalignW=0.
- Link and $0 suppression:
  - LinkM=1, MemtoRegM=1, PCPlus8M=0x0040_0010 → ResultW=0x0040_0010.
  - WriteRegM=0, RegWriteM=1 → RegWriteW=0.
- Stall and flush:
  - Load instruction A, then StallW=1 for 3 cycles while M inputs change → W outputs hold A.
  - FlushW=1 together with StallW=1 → next cycle ValidW=0, RegWriteW=0.
  - DATA_WIDTH=64 rerun: LB at offset 7 selects bits [63:56].
